// File: rtl/evaluate_pawns_taper_if.sv
// Board-evaluation handshake bundle between the pawn evaluators, the taper
// stage and its downstream consumer.
interface evaluate_pawns_taper_if #(
    parameter int EVAL_WIDTH = 0
);
    logic                         board_valid;
    logic [8:0]                   phase;
    logic signed [EVAL_WIDTH-1:0] white_mg;
    logic signed [EVAL_WIDTH-1:0] white_eg;
    logic signed [EVAL_WIDTH-1:0] black_mg;
    logic signed [EVAL_WIDTH-1:0] black_eg;
    logic                         white_valid;
    logic                         black_valid;
    logic                         pawn_clear_eval;
    logic signed [EVAL_WIDTH-1:0] eval;
    logic                         eval_valid;
    logic                         clear_eval;

    modport master (
        output board_valid, phase, white_mg, white_eg, black_mg, black_eg,
        output white_valid, black_valid, clear_eval,
        input  pawn_clear_eval, eval, eval_valid
    );

    modport slave (
        input  board_valid, phase, white_mg, white_eg, black_mg, black_eg,
        input  white_valid, black_valid, clear_eval,
        output pawn_clear_eval, eval, eval_valid
    );
endinterface

// File: rtl/evaluate_pawns_taper.sv
// Combines white and black pawn terms and tapers them between middlegame and
// endgame weights by game phase, producing one saturated score per board.
module evaluate_pawns_taper #(
    parameter int EVAL_WIDTH = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    evaluate_pawns_taper_if.slave bus
);
    localparam int MW = EVAL_WIDTH + 1;
    localparam int PW = EVAL_WIDTH + 12;
    localparam logic signed [PW-1:0] ONE_P   = 1;
    localparam logic signed [PW-1:0] SAT_MAX = (ONE_P <<< (EVAL_WIDTH - 1)) - ONE_P;
    localparam logic signed [PW-1:0] SAT_MIN = -(ONE_P <<< (EVAL_WIDTH - 1));

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PAWN  = 3'd1,
        SUM        = 3'd2,
        MUL        = 3'd3,
        WAIT_CLEAR = 3'd4
    } state_t;

    function automatic logic [8:0] clamp_phase(input logic [8:0] p);
        return (p > 9'd256) ? 9'd256 : p;
    endfunction

    function automatic logic signed [EVAL_WIDTH-1:0] sat_eval(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[EVAL_WIDTH-1:0];
        else if (v < SAT_MIN) return SAT_MIN[EVAL_WIDTH-1:0];
        else                  return v[EVAL_WIDTH-1:0];
    endfunction

    state_t state_q, state_d;
    logic   bv_q;
    logic   arm_q;
    logic   wflag_q, wflag_d;
    logic   bflag_q, bflag_d;
    logic   pce_q, pce_d;
    logic   evv_q, evv_d;
    logic   load_phase, load_terms, load_sum, load_eval;

    logic signed [EVAL_WIDTH-1:0] eval_q, eval_d;
    logic        [8:0]            phase_q;
    logic signed [EVAL_WIDTH-1:0] wmg_q, weg_q, bmg_q, beg_q;
    logic signed [MW-1:0]         mg_q, eg_q;
    logic signed [PW-1:0]         mg_x, eg_x, ph_x, phc_x, prod_t;

    // A start needs a low board_valid sampled since reset, so a level held
    // high across reset release never counts as a fresh rising edge.
    always_comb begin
        state_d    = state_q;
        wflag_d    = wflag_q;
        bflag_d    = bflag_q;
        pce_d      = 1'b0;
        evv_d      = evv_q;
        load_phase = 1'b0;
        load_terms = 1'b0;
        load_sum   = 1'b0;
        load_eval  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.board_valid && !bv_q && arm_q) begin
                    load_phase = 1'b1;
                    state_d    = WAIT_PAWN;
                end
            end
            WAIT_PAWN: begin
                if (!bus.board_valid) begin
                    pce_d   = 1'b1;
                    wflag_d = 1'b0;
                    bflag_d = 1'b0;
                    state_d = IDLE;
                end else if ((wflag_q || bus.white_valid) && (bflag_q || bus.black_valid)) begin
                    load_terms = 1'b1;
                    pce_d      = 1'b1;
                    wflag_d    = 1'b0;
                    bflag_d    = 1'b0;
                    state_d    = SUM;
                end else begin
                    wflag_d = wflag_q || bus.white_valid;
                    bflag_d = bflag_q || bus.black_valid;
                end
            end
            SUM: begin
                load_sum = 1'b1;
                state_d  = MUL;
            end
            MUL: begin
                load_eval = 1'b1;
                evv_d     = 1'b1;
                state_d   = WAIT_CLEAR;
            end
            WAIT_CLEAR: begin
                if (bus.clear_eval) begin
                    evv_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                wflag_d = 1'b0;
                bflag_d = 1'b0;
                evv_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bv_q    <= 1'b0;
            arm_q   <= 1'b0;
            wflag_q <= 1'b0;
            bflag_q <= 1'b0;
            pce_q   <= 1'b0;
            evv_q   <= 1'b0;
            eval_q  <= '0;
        end else begin
            state_q <= state_d;
            bv_q    <= bus.board_valid;
            arm_q   <= arm_q || !bus.board_valid;
            wflag_q <= wflag_d;
            bflag_q <= bflag_d;
            pce_q   <= pce_d;
            evv_q   <= evv_d;
            if (load_eval) eval_q <= eval_d;
        end
    end

    // Data path registers: loaded only under FSM strobes, no reset needed.
    always_ff @(posedge clk) begin
        if (load_phase) phase_q <= clamp_phase(bus.phase);
        if (load_terms) begin
            wmg_q <= bus.white_mg;
            weg_q <= bus.white_eg;
            bmg_q <= bus.black_mg;
            beg_q <= bus.black_eg;
        end
        if (load_sum) begin
            mg_q <= MW'(wmg_q) + MW'(bmg_q);
            eg_q <= MW'(weg_q) + MW'(beg_q);
        end
    end

    // Taper product is at most 2^(EVAL_WIDTH+8) in magnitude, so PW bits
    // carry it exactly; >>> 8 on the signed value floors toward -inf.
    always_comb begin
        mg_x   = PW'(mg_q);
        eg_x   = PW'(eg_q);
        ph_x   = PW'(phase_q);
        phc_x  = PW'(9'd256 - phase_q);
        prod_t = (mg_x * ph_x) + (eg_x * phc_x);
        eval_d = sat_eval(prod_t >>> 8);
    end

    assign bus.pawn_clear_eval = pce_q;
    assign bus.eval            = eval_q;
    assign bus.eval_valid      = evv_q;
endmodule

// File: tb/tb_evaluate_pawns_taper.sv
// Directed bench for evaluate_pawns_taper: two instances (24-bit and 8-bit
// evals) checked every cycle against a cycle-indexed expectation model.
module tb_evaluate_pawns_taper;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    evaluate_pawns_taper_if #(.EVAL_WIDTH(24)) ia ();
    evaluate_pawns_taper_if #(.EVAL_WIDTH(8))  ib ();

    evaluate_pawns_taper #(.EVAL_WIDTH(24)) dut_a (.clk(clk), .reset(rst_n), .bus(ia.slave));
    evaluate_pawns_taper #(.EVAL_WIDTH(8))  dut_b (.clk(clk), .reset(rst_n), .bus(ib.slave));

    logic       bv [2];
    logic       wv [2];
    logic       kv [2];
    logic       ce [2];
    logic [8:0] ph [2];
    int         wm [2];
    int         we [2];
    int         bm [2];
    int         be [2];

    assign ia.board_valid = bv[0];
    assign ia.phase       = ph[0];
    assign ia.white_mg    = wm[0][23:0];
    assign ia.white_eg    = we[0][23:0];
    assign ia.black_mg    = bm[0][23:0];
    assign ia.black_eg    = be[0][23:0];
    assign ia.white_valid = wv[0];
    assign ia.black_valid = kv[0];
    assign ia.clear_eval  = ce[0];
    assign ib.board_valid = bv[1];
    assign ib.phase       = ph[1];
    assign ib.white_mg    = wm[1][7:0];
    assign ib.white_eg    = we[1][7:0];
    assign ib.black_mg    = bm[1][7:0];
    assign ib.black_eg    = be[1][7:0];
    assign ib.white_valid = wv[1];
    assign ib.black_valid = kv[1];
    assign ib.clear_eval  = ce[1];

    wire signed [31:0] ev_a = ia.eval;
    wire signed [31:0] ev_b = ib.eval;

    int     n_chk  = 0;
    int     n_fail = 0;
    int     exp_rise [2];
    int     exp_clr  [2];
    int     exp_pce  [2];
    longint exp_val  [2];
    logic   exp_vld  [2];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Tapered score from first principles: floor division and clamp in plain integers.
    function automatic longint model(input int w, input int phs, input int a, input int b,
                                     input int c, input int e);
        longint p  = (phs > 256) ? 256 : phs;
        longint mg = longint'(a) + longint'(c);
        longint eg = longint'(b) + longint'(e);
        longint t  = mg * p + eg * (256 - p);
        longint q  = t / 256;
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        if ((t % 256 != 0) && (t < 0)) q = q - 1;
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic   a_v;
                logic   a_p;
                longint a_e;
                a_v = (d == 0) ? ia.eval_valid : ib.eval_valid;
                a_p = (d == 0) ? ia.pawn_clear_eval : ib.pawn_clear_eval;
                a_e = (d == 0) ? longint'(ev_a) : longint'(ev_b);
                if (cyc == exp_rise[d]) exp_vld[d] = 1'b1;
                if (cyc == exp_clr[d])  exp_vld[d] = 1'b0;
                chk($sformatf("eval_valid[%0d]", d), a_v, exp_vld[d]);
                chk($sformatf("pawn_clear_eval[%0d]", d), a_p, (cyc == exp_pce[d]));
                if (exp_vld[d]) chk($sformatf("eval[%0d]", d), a_e, exp_val[d]);
            end
        end
    endtask

    task automatic clear_expect();
        for (int d = 0; d < 2; d++) begin
            exp_vld[d]  = 1'b0;
            exp_rise[d] = -1;
            exp_pce[d]  = -1;
            exp_clr[d]  = -1;
        end
    endtask

    // Assert reset mid-cycle, confirm outputs drop without a clock edge, then
    // show that a board_valid held high through release does not start a job.
    task automatic do_reset(input int d);
        clear_expect();
        rst_n = 1'b0;
        #1;
        chk("async_eval_valid", (d == 0) ? ia.eval_valid : ib.eval_valid, 1'b0);
        chk("async_pawn_clear", (d == 0) ? ia.pawn_clear_eval : ib.pawn_clear_eval, 1'b0);
        chk("async_eval", (d == 0) ? longint'(ev_a) : longint'(ev_b), 0);
        tick();
        wv[d] = 1'b0;
        kv[d] = 1'b0;
        tick();
        rst_n = 1'b1;
        bv[d] = 1'b1;
        repeat (4) tick();
        bv[d] = 1'b0;
        tick();
        tick();
    endtask

    // mode 0: normal, 1: reset while in MUL, 2: reset while eval held.
    task automatic run_job(input int d, input int phs, input int a, input int b, input int c,
                           input int e, input int wdel, input int bdel, input int mode);
        int last = (wdel > bdel) ? wdel : bdel;
        wm[d] = a; we[d] = b; bm[d] = c; be[d] = e;
        ph[d] = 9'(phs);
        bv[d] = 1'b1;
        tick();
        for (int i = 0; i <= last; i++) begin
            if (i == wdel) wv[d] = 1'b1;
            if (i == bdel) kv[d] = 1'b1;
            if (i < last) tick();
        end
        exp_val[d]  = model((d == 0) ? 24 : 8, phs, a, b, c, e);
        exp_pce[d]  = cyc + 1;
        exp_rise[d] = cyc + 3;
        tick();
        wv[d] = 1'b0;
        kv[d] = 1'b0;
        ce[d] = 1'b1;
        wm[d] = a + 77;
        bm[d] = c - 33;
        tick();
        ce[d] = 1'b0;
        if (mode == 1) begin
            #1;
            do_reset(d);
            return;
        end
        tick();
        tick();
        tick();
        if (mode == 2) begin
            do_reset(d);
            return;
        end
        ce[d] = 1'b1;
        exp_clr[d] = cyc + 1;
        tick();
        ce[d] = 1'b0;
        bv[d] = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_abort(input int d);
        wm[d] = 10; we[d] = 20; bm[d] = 30; be[d] = 40;
        ph[d] = 9'd128;
        bv[d] = 1'b1;
        tick();
        wv[d] = 1'b1;
        tick();
        bv[d] = 1'b0;
        exp_pce[d] = cyc + 1;
        tick();
        wv[d] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic stimulus();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_eval_valid_a", ia.eval_valid, 1'b0);
        chk("reset_eval_a", longint'(ev_a), 0);
        chk("reset_pawn_clear_b", ib.pawn_clear_eval, 1'b0);
        chk("model_p128", model(24, 128, 100, 50, -40, -10), 50);
        chk("model_p256", model(24, 256, 100, 50, -40, -10), 60);
        chk("model_p0", model(24, 0, 100, 50, -40, -10), 40);
        chk("model_p300", model(24, 300, 100, 50, -40, -10), 60);
        chk("model_floor", model(24, 128, -3, 0, 0, 0), -2);
        chk("model_sat_hi", model(8, 256, 127, 0, 127, 0), 127);
        chk("model_sat_lo", model(8, 256, -128, 0, -128, 0), -128);
        rst_n = 1'b1;
        tick();
        tick();
        run_job(0, 128, 100, 50, -40, -10, 0, 0, 0);
        run_job(0, 256, 100, 50, -40, -10, 0, 0, 0);
        run_job(0, 0, 100, 50, -40, -10, 0, 0, 0);
        run_job(0, 300, 100, 50, -40, -10, 0, 0, 0);
        run_job(0, 128, -3, 0, 0, 0, 0, 0, 0);
        run_job(0, 128, 100, 50, -40, -10, 0, 5, 0);
        run_job(0, 77, -5000, 321, 1234, -999, 3, 1, 0);
        run_job(1, 256, 127, 0, 127, 0, 0, 0, 0);
        run_job(1, 256, -128, 0, -128, 0, 2, 0, 0);
        run_job(1, 100, 60, -70, 20, 10, 1, 1, 0);
        run_abort(0);
        run_job(0, 128, 100, 50, -40, -10, 0, 0, 0);
        run_job(0, 128, 100, 50, -40, -10, 0, 0, 1);
        run_job(0, 200, 100, 50, -40, -10, 0, 0, 0);
        run_job(0, 128, 100, 50, -40, -10, 1, 0, 2);
        run_job(1, 64, -100, 90, -28, 37, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            bv[d] = 1'b0; wv[d] = 1'b0; kv[d] = 1'b0; ce[d] = 1'b0;
            ph[d] = '0; wm[d] = 0; we[d] = 0; bm[d] = 0; be[d] = 0;
            exp_val[d] = 0;
        end
        clear_expect();
        fork
            compare_loop();
            stimulus();
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/evaluate_pawns_taper.md
EVALUATE_PAWNS_TAPER -- requirements
Module: evaluate_pawns_taper

Interface
REQ-001 SHALL have parameter EVAL_WIDTH, default 0 (must be overridden, >= 8): signed width of every eval bus.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset is asynchronous and active-low.
REQ-004 SHALL have port board_valid  input  1  board under evaluation is stable; its rising edge starts a job.
REQ-005 SHALL have port phase  input  9  game phase, 0 = pure endgame, 256 = pure middlegame; sampled at job start.
REQ-006 SHALL have ports white_mg, white_eg, black_mg, black_eg  input  EVAL_WIDTH signed each  pawn terms from the white and black pawn evaluators.
REQ-007 SHALL have ports white_valid, black_valid  input  1 each  per-evaluator result valid; held until that evaluator is cleared.
REQ-008 SHALL have port pawn_clear_eval  output  1  one-cycle pulse releasing both pawn evaluators.
REQ-009 SHALL have port eval  output  EVAL_WIDTH signed  tapered pawn score.
REQ-010 SHALL have port eval_valid  output  1  eval is valid; held until clear_eval.
REQ-011 SHALL have port clear_eval  input  1  downstream consumed eval.

Function
REQ-012 SHALL implement states IDLE, WAIT_PAWN, SUM, MUL, WAIT_CLEAR.
REQ-013 SHALL register board_valid each cycle; in IDLE, board_valid=1 with previous board_valid=0 SHALL capture phase and move to WAIT_PAWN.
REQ-014 SHALL clamp the captured phase: values above 256 SHALL be stored as 256.
REQ-015 In WAIT_PAWN, white_valid and black_valid SHALL each set a sticky flag; the two valids may arrive in any order, in any cycles, or together.
REQ-016 SHALL leave WAIT_PAWN for SUM in the cycle after both sticky flags are set, capturing all four pawn terms in that same transition.
REQ-017 On entering SUM, SHALL pulse pawn_clear_eval for exactly one cycle and clear both sticky flags.
REQ-018 In SUM, SHALL form mg = white_mg + black_mg and eg = white_eg + black_eg at EVAL_WIDTH+1 bits signed, with no overflow.
REQ-019 In MUL, SHALL form t = mg*phase + eg*(256-phase) at full precision, with no intermediate truncation.
REQ-020 On leaving MUL, SHALL set eval = t arithmetic-shifted right 8 (floor toward minus infinity), assert eval_valid, and enter WAIT_CLEAR.
REQ-021 SHALL saturate eval to the signed EVAL_WIDTH range [-2^(EVAL_WIDTH-1), 2^(EVAL_WIDTH-1)-1].
REQ-022 Latency SHALL be 3 cycles from the cycle both evaluator results are valid to eval_valid=1.
REQ-023 eval SHALL stay stable while eval_valid=1.
REQ-024 In WAIT_CLEAR, clear_eval=1 SHALL deassert eval_valid on the next edge and return to IDLE; clear_eval in any other state SHALL be ignored.
REQ-025 If board_valid falls during WAIT_PAWN, SHALL abort: pulse pawn_clear_eval once, clear flags, return to IDLE, no eval_valid.
REQ-026 board_valid edges outside IDLE SHALL NOT restart the job; a new job requires a rising edge seen in IDLE.
REQ-027 An undefined state encoding SHALL recover to IDLE.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, eval_valid=0, pawn_clear_eval=0, eval=0, both sticky flags=0, registered board_valid=0.
REQ-029 Reset asserted mid-job SHALL discard the job; after release, a fresh board_valid rising edge is required to start a new job.

Verification
REQ-030 EVAL_WIDTH=24, phase=128, white_mg/eg=100/50, black_mg/eg=-40/-10, both valids same cycle -> eval=50, eval_valid exactly 3 cycles later, one pawn_clear_eval pulse.
REQ-031 Same terms, phase=256 -> eval=60; phase=0 -> eval=40; phase=300 -> eval=60 (clamped).
REQ-032 mg=-3 (white_mg=-3, others 0), phase=128 -> eval=-2 (floor of -1.5).
REQ-033 EVAL_WIDTH=8, white_mg=black_mg=127, phase=256 -> eval=127 (saturated); both mg=-128 -> eval=-128.
REQ-034 white_valid 5 cycles before black_valid -> single result; board_valid dropped while waiting -> pawn_clear_eval pulse, no eval_valid.
REQ-035 reset=0 asserted in MUL and in WAIT_CLEAR -> eval_valid=0 asynchronously; board_valid held high after reset release -> no job until it toggles low then high.
